alu_sequencer: RTL and testbench

Clocked initiator for the combinational `alu`. It accepts one operation at a time from the control unit over a valid/ready request channel and drives `op1`/`op2`/`func` into the ALU. It waits a fixed settle time, captures `result` and `flags_out`, and returns them over a valid/ready response channel. It also owns the architectural flag register, which it feeds back to the ALU's `flags_in` for BRFL.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_sequencer_if.sv | 41 ++++
 rtl/alu_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, flag bit positions, sequencer states
// and the function-code classification helpers.
package alu_pkg;

    localparam logic [5:0] FUNC_ADD  = 6'b100000;
    localparam logic [5:0] FUNC_SUB  = 6'b100010;
    localparam logic [5:0] FUNC_MUL  = 6'b011000;
    localparam logic [5:0] FUNC_DIV  = 6'b011010;
    localparam logic [5:0] FUNC_AND  = 6'b100100;
    localparam logic [5:0] FUNC_OR   = 6'b100101;
    localparam logic [5:0] FUNC_NOT  = 6'b100111;
    localparam logic [5:0] FUNC_BRFL = 6'b111111;
    localparam logic [5:0] IDLE_FUNC = 6'b000000;

    localparam int FLAG_ABOVE    = 2;
    localparam int FLAG_EQUALS   = 1;
    localparam int FLAG_OVERFLOW = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_EXEC  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic func_supported(input logic [5:0] func);
        case (func)
            FUNC_ADD, FUNC_SUB, FUNC_MUL, FUNC_DIV,
            FUNC_AND, FUNC_OR, FUNC_NOT, FUNC_BRFL: func_supported = 1'b1;
            default:                                func_supported = 1'b0;
        endcase
    endfunction

    // Only the arithmetic group produces architecturally meaningful flags.
    function automatic logic func_sets_flags(input logic [5:0] func);
        case (func)
            FUNC_ADD, FUNC_SUB, FUNC_MUL, FUNC_DIV: func_sets_flags = 1'b1;
            default:                                func_sets_flags = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of the request/response channels, flag register and ALU-facing signals
// around the sequencer; slave is the sequencer side, master its environment.
interface alu_sequencer_if;

    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_func;
    logic [31:0] req_op1;
    logic [31:0] req_op2;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_flags;
    logic        rsp_error;

    logic        flags_clear;
    logic [2:0]  flags;

    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [5:0]  alu_func;
    logic [2:0]  alu_flags_in;
    logic [31:0] alu_result;
    logic [2:0]  alu_flags_out;

    modport slave (
        input  req_valid, req_func, req_op1, req_op2,
        input  rsp_ready, flags_clear, alu_result, alu_flags_out,
        output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_error,
        output flags, alu_op1, alu_op2, alu_func, alu_flags_in
    );

    modport master (
        output req_valid, req_func, req_op1, req_op2,
        output rsp_ready, flags_clear, alu_result, alu_flags_out,
        input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_error,
        input  flags, alu_op1, alu_op2, alu_func, alu_flags_in
    );

endinterface

// File: rtl/alu_sequencer.sv
// Drives one operation at a time into the combinational ALU, waits for it to settle,
// captures the result and returns it; also owns the architectural flag register.
module alu_sequencer #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [5:0]  IDLE_FUNC   = alu_pkg::IDLE_FUNC
) (
    input logic            clock,
    input logic            reset,
    alu_sequencer_if.slave bus
);
    import alu_pkg::*;

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [31:0]      op1_q, op1_d;
    logic [31:0]      op2_q, op2_d;
    logic [5:0]       func_q, func_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      result_q, result_d;
    logic [2:0]       rsp_flags_q, rsp_flags_d;
    logic             error_q, error_d;
    logic [2:0]       flags_q, flags_d;
    logic             capture;

    assign capture = (state_q == ST_EXEC) && (cnt_q == CNT_LAST);

    // A clear always beats a coinciding capture.
    always_comb begin
        flags_d = flags_q;
        if (bus.flags_clear) begin
            flags_d = 3'b000;
        end else if (capture && func_sets_flags(func_q)) begin
            flags_d = bus.alu_flags_out;
        end
    end

    // Unsupported codes still pass through ISSUE (with the ALU parked) so the
    // error response appears one cycle after acceptance.
    always_comb begin
        state_d     = state_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        func_d      = func_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        rsp_flags_d = rsp_flags_q;
        error_d     = error_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (func_supported(bus.req_func)) begin
                        op1_d  = bus.req_op1;
                        op2_d  = bus.req_op2;
                        func_d = bus.req_func;
                    end else begin
                        error_d  = 1'b1;
                        result_d = 32'd0;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (error_q) begin
                    rsp_flags_d = flags_d;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (capture) begin
                    result_d    = bus.alu_result;
                    rsp_flags_d = flags_d;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    error_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op1_q       <= 32'd0;
            op2_q       <= 32'd0;
            func_q      <= IDLE_FUNC;
            cnt_q       <= '0;
            result_q    <= 32'd0;
            rsp_flags_q <= 3'b000;
            error_q     <= 1'b0;
            flags_q     <= 3'b000;
        end else begin
            state_q     <= state_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            func_q      <= func_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            rsp_flags_q <= rsp_flags_d;
            error_q     <= error_d;
            flags_q     <= flags_d;
        end
    end

    assign bus.req_ready    = (state_q == ST_IDLE);
    assign bus.rsp_valid    = (state_q == ST_RESP);
    assign bus.rsp_result   = result_q;
    assign bus.rsp_flags    = rsp_flags_q;
    assign bus.rsp_error    = error_q;
    assign bus.flags        = flags_q;
    assign bus.alu_flags_in = flags_q;
    assign bus.alu_op1      = op1_q;
    assign bus.alu_op2      = op2_q;
    assign bus.alu_func     = (state_q == ST_EXEC) ? func_q : IDLE_FUNC;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed plus randomized bench for alu_sequencer with an event-driven ALU model
// and a transaction-level reference for results, flags, errors and latency.
module tb_alu_sequencer;

    localparam int unsigned WAIT = 1;
    localparam logic [5:0]  IDLE = 6'b000000;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [2:0]  mflags = 3'b000;
    logic [31:0] lastResult;
    logic [2:0]  lastFlags;
    logic        lastError;

    alu_sequencer_if bus ();

    alu_sequencer #(.WAIT_CYCLES(WAIT), .IDLE_FUNC(IDLE)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    function automatic logic isSupported(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b011000, 6'b011010,
                         6'b100100, 6'b100101, 6'b100111, 6'b111111};
    endfunction

    function automatic logic setsFlags(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b011000, 6'b011010};
    endfunction

    function automatic void aluEval(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] fin, output logic [31:0] res, output logic [2:0] fout);
        longint prod;
        logic   ov;
        res  = 32'd0;
        ov   = 1'b0;
        fout = fin;
        case (f)
            6'b100000: begin res = a + b; ov = (a[31] == b[31]) && (res[31] != a[31]); end
            6'b100010: begin res = a - b; ov = (a[31] != b[31]) && (res[31] != a[31]); end
            6'b011000: begin
                prod = longint'($signed(a)) * longint'($signed(b));
                res  = prod[31:0];
                ov   = (prod != longint'($signed(res)));
            end
            6'b011010: begin
                if (b == 32'd0) begin res = 32'd0; ov = 1'b1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin res = a; ov = 1'b1; end
                else res = 32'($signed(a) / $signed(b));
            end
            6'b100100: res = a & b;
            6'b100101: res = a | b;
            6'b100111: res = ~a;
            6'b111111: res = {29'd0, fin};
            default:   fout = 3'b000;
        endcase
        if (setsFlags(f)) fout = {($signed(a) > $signed(b)), (a == b), ov};
    endfunction

    // The ALU only re-evaluates when func changes, like the real block.
    always @(bus.alu_func) begin
        logic [31:0] r;
        logic [2:0]  fo;
        aluEval(bus.alu_func, bus.alu_op1, bus.alu_op2, bus.alu_flags_in, r, fo);
        bus.alu_result    = r;
        bus.alu_flags_out = fo;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] func, input logic [31:0] a, input logic [31:0] b,
                                 input int stall, input bit clearAtCapture);
        logic [31:0] expRes;
        logic [2:0]  aluFlags;
        logic [2:0]  expFlags;
        logic        sup;
        int          expLat;
        int          k;
        sup = isSupported(func);
        @(negedge clock);
        checkOutput("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_func  = func;
        bus.req_op1   = a;
        bus.req_op2   = b;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        bus.req_func  = 6'($urandom);
        bus.req_op1   = $urandom;
        bus.req_op2   = $urandom;
        expFlags = mflags;
        expRes   = 32'd0;
        if (sup) begin
            aluEval(func, a, b, mflags, expRes, aluFlags);
            if (setsFlags(func)) expFlags = aluFlags;
        end
        if (clearAtCapture) expFlags = 3'b000;
        expLat = sup ? 1 + int'(WAIT) : 1;
        k = 0;
        while (!bus.rsp_valid && k <= expLat + 4) begin
            checkOutput("req_ready_busy", 32'(bus.req_ready), 32'd0);
            checkOutput("alu_func_busy", 32'(bus.alu_func), 32'((sup && k >= 1) ? func : IDLE));
            if (sup) begin
                checkOutput("alu_op1", bus.alu_op1, a);
                checkOutput("alu_op2", bus.alu_op2, b);
            end
            if (clearAtCapture && k == expLat - 1) bus.flags_clear = 1'b1;
            @(posedge clock);
            #1;
            k++;
        end
        bus.flags_clear = 1'b0;
        mflags = expFlags;
        checkOutput("rsp_latency", 32'(k), 32'(expLat));
        checkOutput("rsp_result", bus.rsp_result, expRes);
        checkOutput("rsp_flags", 32'(bus.rsp_flags), 32'(expFlags));
        checkOutput("rsp_error", 32'(bus.rsp_error), 32'(!sup));
        checkOutput("flags_reg", 32'(bus.flags), 32'(expFlags));
        checkOutput("alu_flags_in", 32'(bus.alu_flags_in), 32'(expFlags));
        checkOutput("alu_func_resp", 32'(bus.alu_func), 32'(IDLE));
        lastResult = bus.rsp_result;
        lastFlags  = bus.rsp_flags;
        lastError  = bus.rsp_error;
        repeat (stall) begin
            @(negedge clock);
            checkOutput("stall_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("stall_result", bus.rsp_result, expRes);
            checkOutput("stall_flags", 32'(bus.rsp_flags), 32'(expFlags));
            checkOutput("stall_ready", 32'(bus.req_ready), 32'd0);
        end
        @(negedge clock);
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.rsp_ready = 1'b0;
        checkOutput("rsp_drop", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rsp_error_clr", 32'(bus.rsp_error), 32'd0);
        checkOutput("req_ready_back", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [5:0]  rfunc;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [5:0]  funcTable [8];
        funcTable = '{6'b100000, 6'b100010, 6'b011000, 6'b011010,
                      6'b100100, 6'b100101, 6'b100111, 6'b111111};
        bus.req_valid   = 1'b0;
        bus.req_func    = 6'd0;
        bus.req_op1     = 32'd0;
        bus.req_op2     = 32'd0;
        bus.rsp_ready   = 1'b0;
        bus.flags_clear = 1'b0;
        #1 reset = 1'b1;
        #2;
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_flags", 32'(bus.flags), 32'd0);
        checkOutput("rst_alu_func", 32'(bus.alu_func), 32'(IDLE));
        checkOutput("rst_rsp_result", bus.rsp_result, 32'd0);
        checkOutput("rst_rsp_flags", 32'(bus.rsp_flags), 32'd0);
        checkOutput("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
        checkOutput("rst_alu_op1", bus.alu_op1, 32'd0);
        checkOutput("rst_alu_op2", bus.alu_op2, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);

        applyStimulus(6'b100000, 32'd5, 32'd7, 0, 1'b0);
        checkOutput("add_5_7", lastResult, 32'd12);

        applyStimulus(6'b100010, 32'd9, 32'd9, 0, 1'b0);
        checkOutput("sub_eq_result", lastResult, 32'd0);
        checkOutput("sub_eq_flags", 32'(lastFlags), 32'(3'b010));
        @(negedge clock);
        bus.flags_clear = 1'b1;
        @(negedge clock);
        bus.flags_clear = 1'b0;
        mflags = 3'b000;
        checkOutput("flags_cleared", 32'(bus.flags), 32'd0);

        applyStimulus(6'b100010, 32'd9, 32'd4, 0, 1'b0);
        checkOutput("repeat_first", lastResult, 32'd5);
        applyStimulus(6'b100010, 32'd9, 32'd4, 0, 1'b0);
        checkOutput("repeat_second", lastResult, 32'd5);

        applyStimulus(6'b111111, 32'd0, 32'd0, 0, 1'b0);
        checkOutput("brfl_result", lastResult, 32'd4);

        applyStimulus(6'b100010, 32'd9, 32'd9, 0, 1'b0);
        applyStimulus(6'b000001, 32'd1, 32'd2, 0, 1'b0);
        checkOutput("unsup_error", 32'(lastError), 32'd1);
        checkOutput("unsup_result", lastResult, 32'd0);
        checkOutput("unsup_flags", 32'(bus.flags), 32'(3'b010));

        applyStimulus(6'b100100, 32'hF0F0_0000, 32'hFF00_FF00, 0, 1'b0);
        checkOutput("and_result", lastResult, 32'hF000_0000);
        checkOutput("and_flags_held", 32'(bus.flags), 32'(3'b010));

        applyStimulus(6'b100101, 32'd1, 32'd2, 5, 1'b0);
        checkOutput("stall_or_result", lastResult, 32'd3);

        applyStimulus(6'b100000, 32'd3, 32'd3, 0, 1'b1);
        checkOutput("clear_wins", 32'(bus.flags), 32'd0);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 8) == 8) begin
                rfunc = 6'($urandom);
                while (isSupported(rfunc)) rfunc = 6'($urandom);
            end else begin
                rfunc = funcTable[$urandom_range(0, 7)];
            end
            ra = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20)) : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom_range(0, 20));
            applyStimulus(rfunc, ra, rb, $urandom_range(0, 2), 1'b0);
        end

        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_func  = 6'b100000;
        bus.req_op1   = 32'd1;
        bus.req_op2   = 32'd1;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("exec_before_rst", 32'(bus.alu_func), 32'(6'b100000));
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("mid_rst_func", 32'(bus.alu_func), 32'(IDLE));
        checkOutput("mid_rst_flags", 32'(bus.flags), 32'd0);
        checkOutput("mid_rst_result", bus.rsp_result, 32'd0);
        checkOutput("mid_rst_op1", bus.alu_op1, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        mflags = 3'b000;
        repeat (6) begin
            @(negedge clock);
            checkOutput("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
            checkOutput("post_rst_ready", 32'(bus.req_ready), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
